// File: rtl/fft_r2_iter_pkg.sv
// fft_pkg: shared types, state codes, bit reversal and twiddle generation for fft_r2_iter
package fft_pkg;
  localparam int DW_DEF = 16;
  typedef struct packed {
    logic signed [DW_DEF-1:0] re;
    logic signed [DW_DEF-1:0] im;
  } cplx_t;
  typedef logic [1:0] state_t;
  localparam state_t S_LOAD = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_OUT  = 2'd2;
  function automatic logic [7:0] bitrev(input logic [7:0] v, input int bits);
    logic [7:0] r;
    r = '0;
    for (int j = 0; j < bits; j++) r[3'(j)] = v[3'(bits - 1 - j)];
    return r;
  endfunction
  // Integer Taylor series in Q.28 so elaboration needs no real-valued math
  function automatic logic [63:0] twiddle(input int k, input int n, input int frac, input int dw);
    longint x, x2, c, s, tc, ts, r, im, mx;
    x = (longint'(k) * 64'sd1686629713) / longint'(n);
    x2 = (x * x) >>> 28;
    c = 64'sd1 <<< 28;
    s = x;
    tc = c;
    ts = x;
    for (int j = 1; j < 14; j++) begin
      tc = -((tc * x2) >>> 28) / longint'((2 * j - 1) * (2 * j));
      ts = -((ts * x2) >>> 28) / longint'((2 * j) * (2 * j + 1));
      c += tc;
      s += ts;
    end
    mx = (64'sd1 <<< (dw - 1)) - 1;
    r = ((c <<< frac) + (64'sd1 <<< 27)) >>> 28;
    im = ((-s <<< frac) + (64'sd1 <<< 27)) >>> 28;
    r = r > mx ? mx : (r < -mx - 1 ? -mx - 1 : r);
    im = im > mx ? mx : (im < -mx - 1 ? -mx - 1 : im);
    return {r[31:0], im[31:0]};
  endfunction
endpackage

// File: rtl/fft_r2_iter_if.sv
// fft_r2_iter_if: sample-in / bin-out handshake bundle of the iterative FFT
interface fft_r2_iter_if #(parameter int DW = 16, parameter int LOGN = 3);
  logic in_valid, in_ready, scale_en, out_valid, out_ready, out_last, busy;
  logic [2*DW-1:0] in_data, out_data;
  logic [LOGN-1:0] out_idx;
  modport master (output in_valid, in_data, scale_en, out_ready,
                  input in_ready, out_valid, out_data, out_idx, out_last, busy);
  modport slave (input in_valid, in_data, scale_en, out_ready,
                 output in_ready, out_valid, out_data, out_idx, out_last, busy);
endinterface

// File: rtl/fft_r2_iter_bfly.sv
// fft_bfly: combinational radix-2 DIF butterfly, top=A+B, bot=(A-B)*W, optional halving
module fft_bfly #(parameter int DW = 16, parameter int FRAC = 8) (
  input  logic [2*DW-1:0] a_i,
  input  logic [2*DW-1:0] b_i,
  input  logic [2*DW-1:0] w_i,
  input  logic            scale_i,
  output logic [2*DW-1:0] top_o,
  output logic [2*DW-1:0] bot_o
);
  logic signed [DW-1:0] ar, ai, br, bi, wr, wi, xr, xi;
  logic signed [DW:0] sr, si, dr, di;
  logic signed [2*DW-1:0] p_rr, p_ii, p_ri, p_ir;
  always_comb begin
    ar = a_i[2*DW-1:DW];
    ai = a_i[DW-1:0];
    br = b_i[2*DW-1:DW];
    bi = b_i[DW-1:0];
    wr = w_i[2*DW-1:DW];
    wi = w_i[DW-1:0];
    sr = ar + br;
    si = ai + bi;
    dr = ar - br;
    di = ai - bi;
    xr = scale_i ? dr[DW:1] : dr[DW-1:0];
    xi = scale_i ? di[DW:1] : di[DW-1:0];
    p_rr = xr * wr;
    p_ii = xi * wi;
    p_ri = xr * wi;
    p_ir = xi * wr;
    top_o = {scale_i ? sr[DW:1] : sr[DW-1:0], scale_i ? si[DW:1] : si[DW-1:0]};
    bot_o = {DW'(p_rr >>> FRAC) - DW'(p_ii >>> FRAC), DW'(p_ri >>> FRAC) + DW'(p_ir >>> FRAC)};
  end
endmodule

// File: rtl/fft_r2_iter.sv
// fft_r2_iter: in-place radix-2 DIF FFT, serial load, one butterfly per cycle, natural-order output
module fft_r2_iter import fft_pkg::*; #(
  parameter int N    = 8,
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int LOGN = $clog2(N)
) (
  input logic         clk,
  input logic         rst,
  fft_r2_iter_if.slave io
);
  localparam int SW = $clog2(LOGN);
  state_t state_q;
  logic [LOGN-1:0] cnt_q, span, pos, top, bot, rev;
  logic [SW-1:0] stage_q;
  logic [LOGN-2:0] k;
  logic scale_q, b_last, s_last, out_v;
  logic [2*DW-1:0] mem_q [N];
  logic [2*DW-1:0] tw [N/2];
  logic [2*DW-1:0] bf_top, bf_bot;
  for (genvar i = 0; i < N/2; i++) begin : g_tw
    localparam logic [63:0] T = twiddle(i, N, FRAC, DW);
    assign tw[i] = {T[32+:DW], T[0+:DW]};
  end
  // In CALC cnt_q is the butterfly index; top inserts a 0 bit at the span position
  always_comb begin
    span = LOGN'(N/2) >> stage_q;
    pos = cnt_q & (span - LOGN'(1));
    top = ((cnt_q & ~(span - LOGN'(1))) << 1) | pos;
    bot = top | span;
    k = (LOGN-1)'(pos << stage_q);
    rev = LOGN'(bitrev(8'(cnt_q), LOGN));
    b_last = cnt_q == LOGN'(N/2 - 1);
    s_last = stage_q == SW'(LOGN - 1);
    out_v = state_q == S_OUT;
  end
  fft_bfly #(.DW(DW), .FRAC(FRAC)) u_bfly (
    .a_i(mem_q[top]), .b_i(mem_q[bot]), .w_i(tw[k]), .scale_i(scale_q),
    .top_o(bf_top), .bot_o(bf_bot)
  );
  assign io.in_ready = state_q == S_LOAD;
  assign io.busy = state_q != S_LOAD;
  assign io.out_valid = out_v;
  assign io.out_idx = out_v ? cnt_q : '0;
  assign io.out_data = out_v ? mem_q[rev] : '0;
  assign io.out_last = out_v && cnt_q == LOGN'(N - 1);
  always_ff @(posedge clk)
    if (state_q == S_LOAD && io.in_valid) mem_q[cnt_q] <= io.in_data;
    else if (state_q == S_CALC) begin
      mem_q[top] <= bf_top;
      mem_q[bot] <= bf_bot;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_LOAD;
      cnt_q <= '0;
      stage_q <= '0;
      scale_q <= 1'b0;
    end else if (state_q == S_LOAD) begin
      if (io.in_valid) begin
        cnt_q <= cnt_q + LOGN'(1);
        if (cnt_q == '0) scale_q <= io.scale_en;
        if (cnt_q == LOGN'(N - 1)) state_q <= S_CALC;
      end
    end else if (state_q == S_CALC) begin
      cnt_q <= b_last ? '0 : cnt_q + LOGN'(1);
      if (b_last) begin
        stage_q <= s_last ? '0 : stage_q + SW'(1);
        if (s_last) state_q <= S_OUT;
      end
    end else if (io.out_ready) begin
      cnt_q <= cnt_q + LOGN'(1);
      if (cnt_q == LOGN'(N - 1)) state_q <= S_LOAD;
    end
endmodule
